// File: rtl/select_sequencer_if.sv
// Handshake/configuration bundle between the Versat controller and select_sequencer.
interface select_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              running;
    logic              run;
    logic [CNT_W-1:0]  delay;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  duty;
    logic [CNT_W-1:0]  iterations;
    logic [DATA_W-1:0] out0;
    logic              done;

    modport master (
        output running, run, delay, period, duty, iterations,
        input  out0, done
    );

    modport slave (
        input  running, run, delay, period, duty, iterations,
        output out0, done
    );
endinterface

// File: rtl/select_sequencer.sv
// Periodic selector-word generator for a two-input select unit.
// Optional macro SELECT_SEQUENCER_LOOP_EN: repeat the schedule in ACTIVE instead of finishing.
module select_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    select_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, FINISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] duty_s;
    logic [CNT_W-1:0] iter_s;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] iter_cnt;
    logic             start;

    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        return (p == '0) ? CNT_W'(1) : p;
    endfunction

    // A run pulse restarts the schedule from any state except FINISH.
    assign start = bus.run && (state != FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            delay_cnt <= '0;
            period_s  <= '0;
            duty_s    <= '0;
            iter_s    <= '0;
            phase     <= '0;
            iter_cnt  <= '0;
            bus.out0  <= '0;
            bus.done  <= 1'b1;
        end else if (!bus.running) begin
            state    <= IDLE;
            phase    <= '0;
            iter_cnt <= '0;
            bus.out0 <= '0;
            bus.done <= 1'b1;
        end else if (start) begin
            period_s  <= eff_period(bus.period);
            duty_s    <= bus.duty;
            iter_s    <= bus.iterations;
            delay_cnt <= bus.delay;
            phase     <= '0;
            iter_cnt  <= '0;
            bus.out0  <= '0;
            if (bus.delay != '0) begin
                state    <= DELAY;
                bus.done <= 1'b0;
            end else if (bus.iterations != '0) begin
                state    <= ACTIVE;
                bus.done <= 1'b0;
            end else begin
                state    <= FINISH;
                bus.done <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    bus.out0 <= '0;
                    bus.done <= 1'b1;
                end
                DELAY: begin
                    bus.out0  <= '0;
                    delay_cnt <= delay_cnt - CNT_W'(1);
                    if (delay_cnt <= CNT_W'(1)) begin
                        state <= (iter_s == '0) ? FINISH : ACTIVE;
                    end
                end
                ACTIVE: begin
                    bus.out0 <= DATA_W'(phase < duty_s);
                    phase    <= (phase >= period_s - CNT_W'(1)) ? '0 : phase + CNT_W'(1);
                    if (iter_cnt + CNT_W'(1) == iter_s) begin
`ifdef SELECT_SEQUENCER_LOOP_EN
                        iter_cnt <= '0;
                        phase    <= '0;
`else
                        iter_cnt <= iter_cnt + CNT_W'(1);
                        state    <= FINISH;
`endif
                    end else begin
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                end
                FINISH: begin
                    bus.out0 <= '0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
